// File: rtl/fpdiv_pkg.sv
// Shared types and select codes for the fpdiv Goldschmidt sequencer.
// Imported by fpdiv_ctrl.
package fpdiv_pkg;

    // One state per schedule slot of a single division.
    typedef enum logic [2:0] {
        IDLE,
        INIT_N,
        INIT_D,
        ITER_N,
        ITER_D,
        REM,
        DRAIN,
        HOLD
    } fpdiv_ctrl_state_t;

    // mux4 picks which operand/correction pair feeds the multiplier.
    localparam logic [1:0] MUX4_NUM_IA = 2'b00;
    localparam logic [1:0] MUX4_DEN_IA = 2'b01;
    localparam logic [1:0] MUX4_NUM_C  = 2'b10;
    localparam logic [1:0] MUX4_DEN_C  = 2'b11;

    // mux3 picks initial approximation, correction factor or remainder path.
    localparam logic [1:0] MUX3_IA  = 2'b00;
    localparam logic [1:0] MUX3_C   = 2'b01;
    localparam logic [1:0] MUX3_REM = 2'b10;

endpackage

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: sequencer in front of the fpdiv Goldschmidt datapath.
// Accepts one operand pair, walks the fixed iteration schedule, samples
// final_ans after the drain window and holds it until the consumer takes it.
// Optional feature: define FPDIV_CTRL_COUNT_EN to add the div_count output,
// a wrapping count of results handed to the consumer.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int ITERATIONS   = 6,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_num,
    input  logic [31:0] in_denom,
    input  logic        in_rm,
    output logic [31:0] dp_num,
    output logic [31:0] dp_denom,
    output logic        dp_rm,
    output logic        dp_start,
    output logic        en_a,
    output logic        en_b,
    output logic        en_rem,
    output logic [1:0]  sel_mux3,
    output logic [1:0]  sel_mux4,
    input  logic [31:0] dp_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FPDIV_CTRL_COUNT_EN
    ,
    output logic [15:0] div_count
`endif
);

    localparam int IW = $clog2(ITERATIONS + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    fpdiv_ctrl_state_t state;
    fpdiv_ctrl_state_t next_state;

    logic [IW-1:0] iter_cnt;
    logic [IW-1:0] iter_next;
    logic [DW-1:0] drain_cnt;
    logic          last_iter;
    logic          drain_last;
    logic          accept;

    // iter_cnt counts completed N/D pairs including the initial IA pass.
    assign iter_next  = iter_cnt + IW'(1);
    assign last_iter  = (iter_next == IW'(ITERATIONS));
    assign drain_last = (drain_cnt == DW'(1));
    assign accept     = (state == IDLE) && in_valid;

    // State register; reset aborts any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Iteration and drain counters, loaded and stepped by the schedule.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                INIT_D:  iter_cnt  <= IW'(1);
                ITER_D:  iter_cnt  <= iter_next;
                REM:     drain_cnt <= DW'(DRAIN_CYCLES);
                DRAIN:   drain_cnt <= drain_cnt - DW'(1);
                default: ;
            endcase
        end
    end

    // Operand registers hold the last accepted pair until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_num   <= '0;
            dp_denom <= '0;
            dp_rm    <= 1'b0;
        end else if (accept) begin
            dp_num   <= in_num;
            dp_denom <= in_denom;
            dp_rm    <= in_rm;
        end
    end

    // final_ans is sampled on the last drain cycle and held through HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_result <= '0;
        end else if ((state == DRAIN) && drain_last) begin
            out_result <= dp_result;
        end
    end

`ifdef FPDIV_CTRL_COUNT_EN
    // Count results taken by the consumer; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_count <= '0;
        end else if ((state == HOLD) && out_ready) begin
            div_count <= div_count + 16'd1;
        end
    end
`endif

    // Next-state and state-decoded datapath controls.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dp_start   = 1'b0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        en_rem     = 1'b0;
        sel_mux3   = 2'b00;
        sel_mux4   = 2'b00;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = INIT_N;
            end
            INIT_N: begin
                dp_start   = 1'b1;
                sel_mux4   = MUX4_NUM_IA;
                sel_mux3   = MUX3_IA;
                en_a       = 1'b1;
                next_state = INIT_D;
            end
            INIT_D: begin
                dp_start   = 1'b1;
                sel_mux4   = MUX4_DEN_IA;
                sel_mux3   = MUX3_IA;
                en_b       = 1'b1;
                next_state = ITER_N;
            end
            ITER_N: begin
                dp_start   = 1'b1;
                sel_mux4   = MUX4_NUM_C;
                sel_mux3   = MUX3_C;
                en_a       = 1'b1;
                next_state = ITER_D;
            end
            ITER_D: begin
                dp_start   = 1'b1;
                sel_mux4   = MUX4_DEN_C;
                sel_mux3   = MUX3_C;
                en_b       = 1'b1;
                next_state = last_iter ? REM : ITER_N;
            end
            REM: begin
                dp_start   = 1'b1;
                sel_mux4   = MUX4_NUM_C;
                sel_mux3   = MUX3_REM;
                en_rem     = 1'b1;
                next_state = DRAIN;
            end
            DRAIN: begin
                sel_mux4 = MUX4_NUM_C;
                sel_mux3 = MUX3_REM;
                if (drain_last) next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed self-checking bench for fpdiv_ctrl: reset/abort, full schedule
// trace, result backpressure, back-to-back issue and a short-parameter build.
// Define FPDIV_CTRL_COUNT_EN to also exercise div_count.
module tb_fpdiv_ctrl;

    // Expected control vector {in_ready,out_valid,dp_start,en_a,en_b,en_rem,sel_mux3,sel_mux4}
    localparam logic [9:0] V_IDLE   = 10'b1_0_0_000_00_00;
    localparam logic [9:0] V_INIT_N = 10'b0_0_1_100_00_00;
    localparam logic [9:0] V_INIT_D = 10'b0_0_1_010_00_01;
    localparam logic [9:0] V_ITER_N = 10'b0_0_1_100_01_10;
    localparam logic [9:0] V_ITER_D = 10'b0_0_1_010_01_11;
    localparam logic [9:0] V_REM    = 10'b0_0_1_001_10_10;
    localparam logic [9:0] V_DRAIN  = 10'b0_0_0_000_10_10;
    localparam logic [9:0] V_HOLD   = 10'b0_1_0_000_00_00;

    localparam logic [9:0] TRACE1 [0:16] = '{
        V_IDLE, V_INIT_N, V_INIT_D,
        V_ITER_N, V_ITER_D, V_ITER_N, V_ITER_D, V_ITER_N, V_ITER_D,
        V_ITER_N, V_ITER_D, V_ITER_N, V_ITER_D,
        V_REM, V_DRAIN, V_DRAIN, V_HOLD
    };

    localparam logic [9:0] TRACE2 [0:7] = '{
        V_IDLE, V_INIT_N, V_INIT_D, V_ITER_N, V_ITER_D, V_REM, V_DRAIN, V_HOLD
    };

    logic        clk;
    logic        reset;

    // Default-parameter instance signals
    logic        in_valid, in_ready, in_rm, dp_rm, dp_start;
    logic [31:0] in_num, in_denom, dp_num, dp_denom, dp_result, out_result;
    logic        en_a, en_b, en_rem, out_valid, out_ready;
    logic [1:0]  sel_mux3, sel_mux4;

    // Short-parameter instance signals
    logic        b_in_valid, b_in_ready, b_in_rm, b_dp_rm, b_dp_start;
    logic [31:0] b_in_num, b_in_denom, b_dp_num, b_dp_denom, b_dp_result, b_out_result;
    logic        b_en_a, b_en_b, b_en_rem, b_out_valid, b_out_ready;
    logic [1:0]  b_sel_mux3, b_sel_mux4;

`ifdef FPDIV_CTRL_COUNT_EN
    logic [15:0] div_count, b_div_count;
`endif

    int checks = 0;
    int errors = 0;

    fpdiv_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_denom(in_denom), .in_rm(in_rm),
        .dp_num(dp_num), .dp_denom(dp_denom), .dp_rm(dp_rm),
        .dp_start(dp_start), .en_a(en_a), .en_b(en_b), .en_rem(en_rem),
        .sel_mux3(sel_mux3), .sel_mux4(sel_mux4),
        .dp_result(dp_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result)
`ifdef FPDIV_CTRL_COUNT_EN
        , .div_count(div_count)
`endif
    );

    fpdiv_ctrl #(.ITERATIONS(2), .DRAIN_CYCLES(1)) dut_short (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_num(b_in_num), .in_denom(b_in_denom), .in_rm(b_in_rm),
        .dp_num(b_dp_num), .dp_denom(b_dp_denom), .dp_rm(b_dp_rm),
        .dp_start(b_dp_start), .en_a(b_en_a), .en_b(b_en_b), .en_rem(b_en_rem),
        .sel_mux3(b_sel_mux3), .sel_mux4(b_sel_mux4),
        .dp_result(b_dp_result), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_result(b_out_result)
`ifdef FPDIV_CTRL_COUNT_EN
        , .div_count(b_div_count)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [9:0] obs1();
        return {in_ready, out_valid, dp_start, en_a, en_b, en_rem, sel_mux3, sel_mux4};
    endfunction

    function automatic logic [9:0] obs2();
        return {b_in_ready, b_out_valid, b_dp_start, b_en_a, b_en_b, b_en_rem, b_sel_mux3, b_sel_mux4};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] num, input logic [31:0] denom,
                                 input logic rm, input logic [31:0] result);
        in_valid  = 1'b1;
        in_num    = num;
        in_denom  = denom;
        in_rm     = rm;
        dp_result = result;
    endtask

    logic [31:0] opN [0:2] = '{32'h40400000, 32'h41200000, 32'h3f800000};
    logic [31:0] opD [0:2] = '{32'h3f800000, 32'h40000000, 32'h40400000};
    logic [31:0] opR [0:2] = '{32'h40400000, 32'h40a00000, 32'h3eaaaaab};

    initial begin
        int lat;
        int nacc;
        int nres;
        int acc [0:2];

        reset = 1'b0;
        in_valid = 1'b0; in_num = '0; in_denom = '0; in_rm = 1'b0;
        dp_result = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_num = '0; b_in_denom = '0; b_in_rm = 1'b0;
        b_dp_result = '0; b_out_ready = 1'b0;
        acc = '{0, 0, 0};

        // Reset state, with an offer that must be ignored while reset is low
        repeat (2) @(negedge clk);
        applyStimulus(32'h11111111, 32'h22222222, 1'b1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", obs1(), V_IDLE);
        checkOutput("reset_dp_num", dp_num, 32'h0);
        checkOutput("reset_dp_rm", dp_rm, 1'b0);
        checkOutput("reset_out_result", out_result, 32'h0);
        checkOutput("reset_short_ctrl", obs2(), V_IDLE);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset asserted while in INIT_D aborts the division
        applyStimulus(32'h40800000, 32'h40000000, 1'b0, 32'h40000000);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_pre_initd", obs1(), V_INIT_D);
        #1 reset = 1'b0;
        #1;
        checkOutput("abort_ctrl_idle", obs1(), V_IDLE);
        checkOutput("abort_dp_num_clr", dp_num, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_still_idle", obs1(), V_IDLE);

        // Next op after the abort completes normally
        applyStimulus(32'h40000000, 32'h3f800000, 1'b0, 32'h40000000);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        checkOutput("post_abort_latency", lat, 16);
        checkOutput("post_abort_result", out_result, 32'h40000000);
        checkOutput("post_abort_dp_num", dp_num, 32'h40000000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_abort_idle", obs1(), V_IDLE);

        // Full schedule trace: 1.0 / 2.0 with stubbed 0.5
        applyStimulus(32'h3f800000, 32'h40000000, 1'b1, 32'h3f000000);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            checkOutput($sformatf("trace_%0d", k), obs1(), TRACE1[k]);
        end
        checkOutput("trace_result", out_result, 32'h3f000000);
        checkOutput("trace_dp_num", dp_num, 32'h3f800000);
        checkOutput("trace_dp_denom", dp_denom, 32'h40000000);
        checkOutput("trace_dp_rm", dp_rm, 1'b1);

        // Backpressure in HOLD: result stable, no new accept
        dp_result = 32'h12345678;
        in_valid  = 1'b1;
        in_num    = 32'h41000000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_%0d", k), {out_valid, in_ready, out_result}, {1'b1, 1'b0, 32'h3f000000});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("hold_release_idle", obs1(), V_IDLE);
        checkOutput("hold_dp_num_kept", dp_num, 32'h3f800000);

        // Back-to-back: in_valid and out_ready held high across three ops
        out_ready = 1'b1;
        applyStimulus(opN[0], opD[0], 1'b0, 32'h0);
        nacc = 0;
        nres = 0;
        for (int c = 0; c < 80 && nres < 3; c++) begin
            if (out_valid) begin
                checkOutput($sformatf("b2b_result_%0d", nres), out_result, opR[nres]);
                checkOutput($sformatf("b2b_latency_%0d", nres), c - acc[nres], 16);
                checkOutput($sformatf("b2b_dp_num_%0d", nres), dp_num, opN[nres]);
                nres++;
            end
            if (in_ready && in_valid && nacc < 3) begin
                acc[nacc] = c;
                if (nacc > 0) checkOutput($sformatf("b2b_spacing_%0d", nacc), c - acc[nacc-1], 17);
                dp_result = opR[nacc];
                nacc++;
            end else if (!in_ready && nacc < 3) begin
                in_num   = opN[nacc];
                in_denom = opD[nacc];
            end
            if (nacc == 3 && !in_ready) in_valid = 1'b0;
            @(negedge clk);
        end
        checkOutput("b2b_accepts", nacc, 3);
        checkOutput("b2b_results", nres, 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Short build: ITERATIONS=2, DRAIN_CYCLES=1
        b_in_valid  = 1'b1;
        b_in_num    = 32'h40e00000;
        b_in_denom  = 32'h40000000;
        b_dp_result = 32'h40600000;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) begin
                @(negedge clk);
                b_in_valid = 1'b0;
            end
            checkOutput($sformatf("short_trace_%0d", k), obs2(), TRACE2[k]);
        end
        checkOutput("short_result", b_out_result, 32'h40600000);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        checkOutput("short_idle", obs2(), V_IDLE);

`ifdef FPDIV_CTRL_COUNT_EN
        // Completed since the last reset: post-abort op, trace op, three b2b ops
        checkOutput("div_count", div_count, 16'd5);
        checkOutput("short_div_count", b_div_count, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
